// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer for an SDFF chain.
// Runs load/shift/capture per pattern; each unload overlaps the next load's shift.
module scan_chain_ctrl #(
  parameter int unsigned CHAIN_LEN = 8,
  parameter int unsigned PCNT_W    = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [PCNT_W-1:0]    i_num_pat,
  input  logic [CHAIN_LEN-1:0] i_pat_data,
  input  logic                 i_pat_valid,
  output logic                 o_pat_ready,
  output logic                 o_se,
  output logic                 o_si,
  output logic                 o_scan_ce,
  input  logic                 i_so,
  output logic [CHAIN_LEN-1:0] o_resp_data,
  output logic                 o_resp_valid,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned SCNT_W = $clog2(CHAIN_LEN);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShift,
    StCapture,
    StFlush,
    StFin
  } state_e;

  state_e               r_state;
  logic [CHAIN_LEN-1:0] r_pat;
  logic [CHAIN_LEN-1:0] r_resp;
  logic [CHAIN_LEN-1:0] r_resp_data;
  logic [PCNT_W-1:0]    r_num;
  logic [PCNT_W-1:0]    r_pcnt;
  logic [SCNT_W-1:0]    r_scnt;
  logic                 r_pat_ready;
  logic                 r_se;
  logic                 r_si;
  logic                 r_scan_ce;
  logic                 r_resp_valid;
  logic                 r_busy;
  logic                 r_done;

  logic [CHAIN_LEN-1:0] w_resp_nxt;
  logic [PCNT_W-1:0]    w_pcnt_nxt;

  assign w_resp_nxt = {r_resp[CHAIN_LEN-2:0], i_so};
  assign w_pcnt_nxt = r_pcnt + PCNT_W'(1);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_pat        <= '0;
      r_resp       <= '0;
      r_resp_data  <= '0;
      r_num        <= '0;
      r_pcnt       <= '0;
      r_scnt       <= '0;
      r_pat_ready  <= 1'b0;
      r_se         <= 1'b0;
      r_si         <= 1'b0;
      r_scan_ce    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_done       <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_busy <= 1'b1;
            if (i_num_pat == '0) begin
              r_state <= StFin;
              r_done  <= 1'b1;
            end else begin
              r_state     <= StLoad;
              r_num       <= i_num_pat;
              r_pcnt      <= '0;
              r_pat_ready <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (i_pat_valid) begin
            // MSB goes out first; the remaining bits queue up behind it.
            r_si        <= i_pat_data[CHAIN_LEN-1];
            r_pat       <= {i_pat_data[CHAIN_LEN-2:0], 1'b0};
            r_scnt      <= '0;
            r_pat_ready <= 1'b0;
            r_se        <= 1'b1;
            r_scan_ce   <= 1'b1;
            r_state     <= StShift;
          end
        end
        StShift: begin
          r_resp <= w_resp_nxt;
          if (r_scnt == SCNT_LAST) begin
            r_state <= StCapture;
            r_se    <= 1'b0;
            r_si    <= 1'b0;
            // The first pattern unloads stale chain contents, so nothing is reported.
            if (r_pcnt != '0) begin
              r_resp_valid <= 1'b1;
              r_resp_data  <= w_resp_nxt;
            end
          end else begin
            r_scnt <= r_scnt + SCNT_W'(1);
            r_si   <= r_pat[CHAIN_LEN-1];
            r_pat  <= {r_pat[CHAIN_LEN-2:0], 1'b0};
          end
        end
        StCapture: begin
          r_pcnt <= w_pcnt_nxt;
          if (w_pcnt_nxt == r_num) begin
            r_state <= StFlush;
            r_se    <= 1'b1;
            r_scnt  <= '0;
          end else begin
            r_state     <= StLoad;
            r_scan_ce   <= 1'b0;
            r_pat_ready <= 1'b1;
          end
        end
        StFlush: begin
          r_resp <= w_resp_nxt;
          if (r_scnt == SCNT_LAST) begin
            r_state      <= StFin;
            r_se         <= 1'b0;
            r_scan_ce    <= 1'b0;
            r_resp_valid <= 1'b1;
            r_resp_data  <= w_resp_nxt;
            r_done       <= 1'b1;
          end else begin
            r_scnt <= r_scnt + SCNT_W'(1);
          end
        end
        StFin: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_pat_ready  = r_pat_ready;
  assign o_se         = r_se;
  assign o_si         = r_si;
  assign o_scan_ce    = r_scan_ce;
  assign o_resp_data  = r_resp_data;
  assign o_resp_valid = r_resp_valid;
  assign o_busy       = r_busy;
  assign o_done       = r_done;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Directed bench for scan_chain_ctrl with a 4-cell behavioural SDFF chain.
module tb_scan_chain_ctrl;

  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [7:0]   num;
  logic [L-1:0] pat_data;
  logic         pat_valid;
  logic         pat_ready;
  logic         se;
  logic         si;
  logic         scan_ce;
  logic         so;
  logic [L-1:0] resp_data;
  logic         resp_valid;
  logic         busy;
  logic         done;

  logic [L-1:0] chain = '0;
  logic [L-1:0] di_const = 4'b0110;
  bit           di_inv = 1'b0;
  logic [L-1:0] pats [2] = '{4'b1011, 4'b0001};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // DI is either a fixed word or the inverse of each cell's current Q.
  assign so = chain[L-1];
  always @(posedge clk) begin
    if (scan_ce) chain <= se ? {chain[L-2:0], si} : (di_inv ? ~chain : di_const);
  end

  scan_chain_ctrl #(
    .CHAIN_LEN(L),
    .PCNT_W   (8)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_num_pat   (num),
    .i_pat_data  (pat_data),
    .i_pat_valid (pat_valid),
    .o_pat_ready (pat_ready),
    .o_se        (se),
    .o_si        (si),
    .o_scan_ce   (scan_ce),
    .i_so        (so),
    .o_resp_data (resp_data),
    .o_resp_valid(resp_valid),
    .o_busy      (busy),
    .o_done      (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input int p, input bit inv, input int stall,
                     input bit mid_start, input int exp_done, input int exp_se,
                     input logic [15:0] exp_si, input logic [3:0] exp_r0,
                     input logic [3:0] exp_rl);
    int           done_cyc = -1;
    int           se_n = 0;
    int           ce_n = 0;
    int           ready_n = 0;
    int           busy_low = 0;
    int           pat_idx = 0;
    int           stall_left = stall;
    bit           fin = 1'b0;
    bit           mid_done = 1'b0;
    logic [15:0]  si_log = '0;
    logic [L-1:0] snap = '0;
    logic [L-1:0] resp_q [$];
    di_inv = inv;
    @(negedge clk);
    start = 1'b1;
    num   = 8'(p);
    @(posedge clk);
    #1;
    start = 1'b0;
    num   = 8'hAA;
    for (int c = 1; c <= 3000 && !fin; c++) begin
      @(negedge clk);
      if (!busy) busy_low++;
      if (se) begin
        se_n++;
        si_log = {si_log[14:0], si};
      end
      if (scan_ce) ce_n++;
      if (resp_valid) resp_q.push_back(resp_data);
      if (done) begin
        done_cyc = c;
        fin = 1'b1;
      end
      start = 1'b0;
      if (mid_start && se_n == 2 && !mid_done) begin
        start    = 1'b1;
        num      = 8'd5;
        mid_done = 1'b1;
      end
      if (pat_ready) begin
        ready_n++;
        if (pat_idx == 1 && stall_left > 0) begin
          pat_valid = 1'b0;
          if (stall_left == stall) snap = chain;
          else chk({tag, " stall_chain"}, 32'(chain), 32'(snap));
          chk({tag, " stall_se_ce"}, {30'd0, se, scan_ce}, 32'd0);
          stall_left--;
        end else begin
          if (pat_idx == 1 && stall > 0) chk({tag, " stall_chain_end"}, 32'(chain), 32'(snap));
          pat_valid = 1'b1;
          pat_data  = pats[pat_idx % 2];
          pat_idx++;
        end
      end else begin
        pat_valid = 1'b0;
      end
    end
    chk({tag, " done_cycle"}, done_cyc, exp_done);
    chk({tag, " busy_low_in_run"}, busy_low, 0);
    chk({tag, " se_cycles"}, se_n, exp_se);
    chk({tag, " ce_cycles"}, ce_n, exp_se + p);
    chk({tag, " ready_cycles"}, ready_n, p + stall);
    chk({tag, " si_seq"}, 32'(si_log), 32'(exp_si));
    chk({tag, " resp_count"}, resp_q.size(), p);
    if (resp_q.size() > 0) begin
      chk({tag, " resp_first"}, 32'(resp_q[0]), 32'(exp_r0));
      chk({tag, " resp_last"}, 32'(resp_q[resp_q.size()-1]), 32'(exp_rl));
    end
    @(negedge clk);
    chk({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    bit seen;
    rst_n     = 1'b0;
    start     = 1'b0;
    num       = '0;
    pat_data  = '0;
    pat_valid = 1'b0;
    #3;
    chk("reset outs", {se, si, scan_ce, pat_ready, resp_valid, busy, done, resp_data}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run("p1", 1, 1'b0, 0, 1'b0, 11, 8, 16'h00B0, 4'b0110, 4'b0110);

    // Abort mid-SHIFT with an asynchronous reset between edges.
    @(negedge clk);
    start     = 1'b1;
    num       = 8'd2;
    pat_valid = 1'b1;
    pat_data  = 4'b1011;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen  = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (se) seen = 1'b1;
    end
    chk("rst_mid reached_shift", {31'd0, seen}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid async_fall", {28'd0, se, scan_ce, busy, pat_ready}, 32'd0);
    pat_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("rst_idle outs", {se, si, scan_ce, pat_ready, resp_valid, busy, done, resp_data}, 0);
    end

    run("p2", 2, 1'b1, 0, 1'b0, 17, 12, 16'h0B10, 4'b0100, 4'b1110);
    run("stall", 2, 1'b1, 3, 1'b0, 20, 12, 16'h0B10, 4'b0100, 4'b1110);
    run("p0", 0, 1'b0, 0, 1'b0, 1, 0, 16'h0000, 4'b0000, 4'b0000);
    run("mid_start", 2, 1'b1, 0, 1'b1, 17, 12, 16'h0B10, 4'b0100, 4'b1110);
    run("p255", 255, 1'b1, 0, 1'b0, 1535, 1024, 16'hB1B0, 4'b0100, 4'b0100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Sequencer for a scan chain built from SDFF cells: it drives the chain's scan-enable (SE), scan-in (SI) and a chain clock-enable, and samples scan-out (SO). It runs a programmed number of test patterns: load, shift, capture, and unload overlapped with the next load. It accepts parallel patterns through a valid/ready handshake and returns parallel responses. It sits between the pattern source/checker and the SDFF chain in the test datapath.

## Interface
- CHAIN_LEN, 8: number of SDFF cells in the chain (≥2).
- PCNT_W, 8: width of the pattern-count input.

- CLK  in  1  rising-edge clock, shared with the chain.
- RSTn  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle run request, sampled in IDLE only.
- NUM_PAT  in  PCNT_W  number of patterns for the run, sampled with START.
- PAT_DATA  in  CHAIN_LEN  pattern; bit j is the value for chain cell j.
- PAT_VALID  in  1  PAT_DATA valid.
- PAT_READY  out  1  controller accepts PAT_DATA.
- SE  out  1  scan enable to every SDFF (1 = SI path, 0 = DI path).
- SI  out  1  serial data into chain cell 0.
- SCAN_CE  out  1  chain clock enable; the chain updates only when it is 1.
- SO  in  1  serial data from chain cell CHAIN_LEN-1.
- RESP_DATA  out  CHAIN_LEN  captured response; bit j is the value captured in cell j.
- RESP_VALID  out  1  one-cycle pulse, RESP_DATA valid.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse at run end.

## Operation
- States: IDLE, LOAD, SHIFT, CAPTURE, FLUSH, FIN.
- IDLE: all outputs 0.
  - START=1 with NUM_PAT=0 → FIN.
  - START=1 with NUM_PAT>0 → LOAD; latch NUM_PAT and clear the pattern counter.
- LOAD: PAT_READY=1, SE=0, SCAN_CE=0, so the chain holds.
  - On PAT_VALID&&PAT_READY: latch PAT_DATA into the shift register, clear the shift counter, go to SHIFT.
  - If PAT_VALID stays low, remain in LOAD indefinitely.
- SHIFT: exactly CHAIN_LEN cycles with SE=1 and SCAN_CE=1.
  - SI carries the pattern MSB first: pat[CHAIN_LEN-1] first, pat[0] last.
  - On each edge the response register takes resp <= {resp[CHAIN_LEN-2:0], SO}.
  - After the last shift cycle, if this is not the first pattern of the run, pulse RESP_VALID with the previous pattern's response. Then go to CAPTURE.
- CAPTURE: one cycle with SE=0 and SCAN_CE=1, so the chain loads DI. Increment the pattern counter.
  - Counter < NUM_PAT → LOAD.
  - Otherwise → FLUSH.
- FLUSH: CHAIN_LEN cycles with SE=1, SCAN_CE=1 and SI=0, shifting out the last response. Then pulse RESP_VALID and go to FIN.
- FIN: DONE=1 for one cycle → IDLE.
- SI=0 in every state except SHIFT.
- START is ignored while BUSY=1.
- NUM_PAT changes during a run have no effect.
- The shift counter and pattern counter wrap-free:
  - The shift counter is sized for 0..CHAIN_LEN-1.
  - The pattern counter is PCNT_W bits and compares for equality with the latched NUM_PAT.
  - NUM_PAT = 2^PCNT_W-1 must run to completion.

## Timing
- Reset (RSTn=0), asynchronously with no clock edge required:
  - State = IDLE.
  - SE, SI, SCAN_CE, PAT_READY, RESP_VALID, BUSY, DONE = 0; RESP_DATA = 0.
  - Chain contents are not touched.
- All outputs are driven from registers or the state register only; there is no combinational input-to-output path.
- Cycle counting starts at the edge that samples START; cycle 1 is the next cycle.
  - With PAT_VALID always 1, DONE is high in cycle P·(CHAIN_LEN+2)+CHAIN_LEN+1 for P>0.
  - For P=0, DONE is high in cycle 1.
- Each cycle PAT_VALID is low in LOAD adds exactly one cycle to the run.
- RESP_VALID fires in the last SHIFT cycle of patterns 2..P and in the last FLUSH cycle, so P pulses per run. RESP_DATA holds its value until the next pulse.
- Reset mid-run aborts the run. No DONE and no RESP_VALID are issued; a new START after release runs normally.

## Test plan
- Reset check: assert RSTn=0 mid-SHIFT between clock edges → SE, SCAN_CE, BUSY and PAT_READY fall immediately. After release with no START, outputs stay 0 for 10 cycles.
- Single pattern, CHAIN_LEN=4, NUM_PAT=1, PAT_DATA=4'b1011, DI of the SDFF chain tied to 4'b0110:
  - SI during SHIFT = 1,0,1,1.
  - One RESP_VALID with RESP_DATA=4'b0110.
  - DONE in cycle 11.
- Two patterns back-to-back, CHAIN_LEN=4, DI = inverted Q of each cell, patterns 4'b1011 then 4'b0001:
  - RESP_VALID pulses carry 4'b0100 then 4'b1110.
  - DONE in cycle 17.
- Stall: same as the previous scenario but with PAT_VALID low for 3 cycles before the second pattern:
  - SCAN_CE=0 and SE=0 throughout the stall, and chain contents stay unchanged.
  - Same responses, DONE in cycle 20.
- NUM_PAT=0: START → BUSY for one cycle, DONE in cycle 1. SE, SCAN_CE and PAT_READY are never asserted.
- START pulse issued during SHIFT of a 2-pattern run → ignored. Run timing and responses are identical to the back-to-back two-pattern scenario.
